// File: rtl/pipe_sched_if.sv
// Pipeline <-> scheduler handshake bundle: ID decode fields, writeback, branch
// resolution in one direction; stall/flush/issue controls and scoreboard view back.
interface pipe_sched_if #(
    parameter int NREG = 32,
    parameter int RIDX = 5
);
    logic            id_valid;
    logic [RIDX-1:0] id_rs1;
    logic [RIDX-1:0] id_rs2;
    logic [RIDX-1:0] id_rd;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic            id_writes_rd;
    logic            id_long;
    logic            wb_valid;
    logic [RIDX-1:0] wb_rd;
    logic            br_taken;
    logic            issue;
    logic            stall_if;
    logic            stall_id;
    logic            flush_id;
    logic            flush_ex;
    logic [NREG-1:0] pending;
    logic            busy;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_writes_rd, id_long, wb_valid, wb_rd, br_taken,
        input  issue, stall_if, stall_id, flush_id, flush_ex, pending, busy
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_writes_rd, id_long, wb_valid, wb_rd, br_taken,
        output issue, stall_if, stall_id, flush_id, flush_ex, pending, busy
    );
endinterface

// File: rtl/pipe_sched.sv
// Issue scheduler / hazard controller for a 4-stage IF/ID/RF/EX pipeline.
// Optional macro PIPE_SCHED_PERF_EN adds stall/flush performance counters.
module pipe_sched #(
    parameter int NREG         = 32,
    parameter int RIDX         = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    pipe_sched_if.slave bus
`ifdef PIPE_SCHED_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) + 1 : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NREG-1:0] pending, clr_mask, set_mask, pend_eff;
    logic            hazard, issue, stall, flush_id, flush_ex;

    function automatic logic [NREG-1:0] onehot(input logic [RIDX-1:0] idx);
        logic [NREG-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    // A writeback in this cycle already releases its dependents.
    always_comb begin
        clr_mask = (bus.wb_valid && bus.wb_rd != '0) ? onehot(bus.wb_rd) : '0;
        pend_eff = pending & ~clr_mask;
        hazard   = bus.id_valid &
                   ((bus.id_uses_rs1  & (bus.id_rs1 != '0) & pend_eff[bus.id_rs1]) |
                    (bus.id_uses_rs2  & (bus.id_rs2 != '0) & pend_eff[bus.id_rs2]) |
                    (bus.id_writes_rd & (bus.id_rd  != '0) & pend_eff[bus.id_rd]));
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        issue     = 1'b0;
        stall     = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (bus.br_taken) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nxt = FLUSH;
                            cnt_nxt   = CNT_RELOAD;
                        end
                    end else begin
                        stall = hazard;
                        issue = bus.id_valid & ~hazard;
                    end
                end
                FLUSH: begin
                    flush_id = 1'b1;
                    if (bus.br_taken) begin
                        flush_ex = 1'b1;
                        cnt_nxt  = CNT_RELOAD;
                    end else if (cnt == CNT_ONE) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Only an accepted long op reserves its rd; x0 is never tracked.
    assign set_mask = (issue && bus.id_long && bus.id_writes_rd && bus.id_rd != '0)
                      ? onehot(bus.id_rd) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            cnt     <= '0;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign bus.issue    = issue;
    assign bus.stall_if = stall;
    assign bus.stall_id = stall;
    assign bus.flush_id = flush_id;
    assign bus.flush_ex = flush_ex;
    assign bus.pending  = pending;
    assign bus.busy     = |pending;

`ifdef PIPE_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_id) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_sched.sv
// Scoreboard bench for pipe_sched: each driven cycle queues its expected controls,
// which are popped and compared on the following falling edge.
module tb_pipe_sched;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_sched_if #(.NREG(32), .RIDX(5)) bus ();

`ifdef PIPE_SCHED_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    pipe_sched #(.NREG(32), .RIDX(5), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef PIPE_SCHED_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        iss;
        logic        stl;
        logic        fid;
        logic        fex;
        logic [31:0] pend;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input string tag, input logic v,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wr, input logic lng,
                         input logic wbv, input logic [4:0] wbr, input logic br,
                         input logic e_iss, input logic e_stl, input logic e_fid,
                         input logic e_fex, input logic [31:0] e_pend);
        exp_t e;
        @(posedge clk);
        #1;
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_uses_rs1  = u1;
        bus.id_rs2       = rs2;
        bus.id_uses_rs2  = u2;
        bus.id_rd        = rd;
        bus.id_writes_rd = wr;
        bus.id_long      = lng;
        bus.wb_valid     = wbv;
        bus.wb_rd        = wbr;
        bus.br_taken     = br;
        e.tag  = tag;
        e.iss  = e_iss;
        e.stl  = e_stl;
        e.fid  = e_fid;
        e.fex  = e_fex;
        e.pend = e_pend;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".issue"},    {31'd0, bus.issue},    {31'd0, e.iss});
            check({e.tag, ".stall_if"}, {31'd0, bus.stall_if}, {31'd0, e.stl});
            check({e.tag, ".stall_id"}, {31'd0, bus.stall_id}, {31'd0, e.stl});
            check({e.tag, ".flush_id"}, {31'd0, bus.flush_id}, {31'd0, e.fid});
            check({e.tag, ".flush_ex"}, {31'd0, bus.flush_ex}, {31'd0, e.fex});
            check({e.tag, ".pending"},  bus.pending,           e.pend);
            check({e.tag, ".busy"},     {31'd0, bus.busy},     {31'd0, (e.pend != 32'd0)});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        bus.id_valid     = 1'b1;
        bus.id_rs1       = 5'd0;
        bus.id_uses_rs1  = 1'b0;
        bus.id_rs2       = 5'd0;
        bus.id_uses_rs2  = 1'b0;
        bus.id_rd        = 5'd3;
        bus.id_writes_rd = 1'b1;
        bus.id_long      = 1'b1;
        bus.wb_valid     = 1'b0;
        bus.wb_rd        = 5'd0;
        bus.br_taken     = 1'b1;
        #2;
        check("rst.issue",    {31'd0, bus.issue},    32'd0);
        check("rst.stall_id", {31'd0, bus.stall_id}, 32'd0);
        check("rst.flush_id", {31'd0, bus.flush_id}, 32'd0);
        check("rst.flush_ex", {31'd0, bus.flush_ex}, 32'd0);
        check("rst.pending",  bus.pending,           32'd0);
        check("rst.busy",     {31'd0, bus.busy},     32'd0);
        #10;
        bus.id_valid = 1'b0;
        bus.br_taken = 1'b0;
        bus.id_long  = 1'b0;
        reset        = 1'b0;

        //    tag             v rs1 u1 rs2 u2 rd wr lg wb wbr br  is st fi fe pend
        drive("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0);
        drive("ld_r5",        1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,  1, 0, 0, 0, 32'h0);
        drive("raw_r5_a",     1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0,  0, 1, 0, 0, 32'h20);
        drive("raw_r5_b",     1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0,  0, 1, 0, 0, 32'h20);
        drive("raw_r5_wb",    1, 5, 1, 0, 0, 6, 1, 0, 1, 5, 0,  1, 0, 0, 0, 32'h20);
        drive("after_wb5",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0);
        drive("ld_r7",        1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,  1, 0, 0, 0, 32'h0);
        drive("ld_r7_wb7",    1, 0, 0, 0, 0, 7, 1, 1, 1, 7, 0,  1, 0, 0, 0, 32'h80);
        drive("waw_r7",       1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  0, 1, 0, 0, 32'h80);
        drive("wb_r7",        0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 0, 0, 32'h80);
        drive("wb_r9_stray",  0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  0, 0, 0, 0, 32'h0);
        drive("br_run",       1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1,  0, 0, 1, 1, 32'h0);
        drive("flush_ld_r12", 1, 0, 0, 0, 0,12, 1, 1, 0, 0, 0,  0, 0, 1, 0, 32'h0);
        drive("post_flush",   1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0);
        drive("ld_r10",       1, 0, 0, 0, 0,10, 1, 1, 0, 0, 0,  1, 0, 0, 0, 32'h0);
        drive("br_vs_stall",  1,10, 1, 0, 0,11, 1, 1, 0, 0, 1,  0, 0, 1, 1, 32'h400);
        drive("br_in_flush",  1,10, 1, 0, 0,11, 1, 1, 0, 0, 1,  0, 0, 1, 1, 32'h400);
        drive("flush_tail",   1,10, 1, 0, 0,11, 1, 1, 0, 0, 0,  0, 0, 1, 0, 32'h400);
        drive("stall_r10",    1,10, 1, 0, 0,11, 1, 1, 0, 0, 0,  0, 1, 0, 0, 32'h400);
        drive("wb_r10_issue", 1,10, 1, 0, 0,11, 1, 1, 1,10, 0,  1, 0, 0, 0, 32'h400);
        drive("r11_pending",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h800);
        drive("wb_r11",       0, 0, 0, 0, 0, 0, 0, 0, 1,11, 0,  0, 0, 0, 0, 32'h800);
        drive("x0_long",      1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 32'h0);
        drive("x0_read",      1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 32'h0);
        drive("ld_r8",        1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0,  1, 0, 0, 0, 32'h0);
        drive("raw_rs2_r8",   1, 0, 0, 8, 1, 9, 1, 0, 0, 0, 0,  0, 1, 0, 0, 32'h100);
        drive("ld_r5_again",  1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,  1, 0, 0, 0, 32'h100);
        drive("br_pend",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 32'h120);

        // Now sitting in FLUSH with r5/r8 outstanding; reset mid-cycle.
        @(posedge clk);
        #1;
        bus.br_taken = 1'b0;
        check("pre_rst.flush_id", {31'd0, bus.flush_id}, 32'd1);
        check("pre_rst.pending",  bus.pending,           32'h120);
`ifdef PIPE_SCHED_PERF_EN
        check("pre_rst.perf_stall", perf_stall_cnt, 32'd5);
        check("pre_rst.perf_flush", perf_flush_cnt, 32'd6);
`endif
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst.pending",  bus.pending,           32'd0);
        check("mid_rst.busy",     {31'd0, bus.busy},     32'd0);
        check("mid_rst.flush_id", {31'd0, bus.flush_id}, 32'd0);
`ifdef PIPE_SCHED_PERF_EN
        check("mid_rst.perf_stall", perf_stall_cnt, 32'd0);
        check("mid_rst.perf_flush", perf_flush_cnt, 32'd0);
`endif
        #3;
        reset = 1'b0;

        drive("ld_r4",        1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0,  1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++)
            drive("stall_r4",  1, 4, 1, 0, 0, 6, 1, 0, 0, 0, 0,  0, 1, 0, 0, 32'h10);
        drive("idle_end",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h10);
`ifdef PIPE_SCHED_PERF_EN
        check("post.perf_stall", perf_stall_cnt, 32'd3);
        check("post.perf_flush", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pipe_sched.md
Name: pipe_sched

Overview:
- Issue scheduler and hazard controller for the 4-stage IF/ID/RF/EX pipeline.
- Keeps a per-register scoreboard of in-flight long-latency writes (loads, multi-cycle ALU ops).
- Stalls IF/ID on RAW/WAW hazards against pending registers.
- Sequences a multi-cycle flush after a taken branch; sits beside the pipeline and drives its stall/flush/issue controls.

Parameters:
- NREG, 32: architectural register count; scoreboard width.
- RIDX, 5: register index width (log2 NREG).
- FLUSH_CYCLES, 2: total cycles flush_id stays high per taken branch (>=1).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a valid decoded instruction
- id_rs1  in  RIDX  source register 1 index
- id_rs2  in  RIDX  source register 2 index
- id_rd  in  RIDX  destination register index
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2
- id_writes_rd  in  1  instruction writes rd
- id_long  in  1  instruction is long-latency; its rd completes via wb port
- wb_valid  in  1  long-latency writeback completing this cycle
- wb_rd  in  RIDX  register being written back
- br_taken  in  1  EX resolved a taken branch this cycle
- issue  out  1  ID instruction accepted into RF/EX this cycle
- stall_if  out  1  hold PC/IF register
- stall_id  out  1  hold ID register
- flush_id  out  1  squash ID contents (insert bubble)
- flush_ex  out  1  squash EX-bound instruction
- pending  out  NREG  scoreboard bits (debug / test visibility)
- busy  out  1  OR of pending

Behaviour:
- Reset (async, any time, including mid-flush): pending=0, FSM=RUN, flush counter=0, all outputs 0.
- Scoreboard and masks:
  - clr_mask = one-hot(wb_rd) when wb_valid and wb_rd!=0, else 0.
  - pend_eff = pending & ~clr_mask, combinational; a writeback releases dependents in the same cycle.
- hazard = id_valid & ((id_uses_rs1 & id_rs1!=0 & pend_eff[id_rs1]) | (id_uses_rs2 & id_rs2!=0 & pend_eff[id_rs2]) | (id_writes_rd & id_rd!=0 & pend_eff[id_rd])). The third term covers WAW.
- FSM states:
  - RUN: br_taken=1 -> flush_id=1 and flush_ex=1 this cycle, issue=0, stall_*=0. If FLUSH_CYCLES>1, load cnt=FLUSH_CYCLES-1 and go to FLUSH; else stay in RUN.
  - FLUSH: flush_id=1, flush_ex=0, issue=0, stall_*=0; cnt decrements each cycle; cnt reaching 1 -> RUN next cycle. br_taken=1 in FLUSH -> flush_ex=1 that cycle and cnt reloads to FLUSH_CYCLES-1.
- Priority: reset > br_taken/flush > hazard stall > issue.
- In RUN with br_taken=0:
  - stall_if = stall_id = hazard.
  - issue = id_valid & ~hazard.
- Scoreboard update (next edge):
  - pending <= (pending & ~clr_mask) | set_mask.
  - set_mask = one-hot(id_rd) when issue & id_long & id_writes_rd & id_rd!=0.
  - Set and clear of the same register in one cycle: set wins, bit ends 1.
  - Bit 0 is never set.
- Squashed instructions (flushed, or not issued) never set pending.
- A wb_valid for a register whose pending bit is 0 is ignored; no error.
- Latency: hazard->stall is combinational (0 cycles); issue->pending visible next cycle; wb->release is same cycle.

Optional Feature:
- Macro: PIPE_SCHED_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments each cycle stall_id=1.
  - perf_flush_cnt increments each cycle flush_id=1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Issue long op rd=5; next cycle ID reads rs1=5 -> stall_if=stall_id=1, issue=0 and pending[5]=1 until wb_valid wb_rd=5; issue=1 in that wb cycle; pending=0 next cycle.
- Long op rd=7 issues while wb_valid wb_rd=7 in the same cycle -> pending[7]=1 afterwards (set wins).
- br_taken pulse with FLUSH_CYCLES=2 -> flush_id=1 for exactly 2 cycles; flush_ex=1 in the first only; issue=0 both cycles; RUN on the third.
- br_taken while the stall condition is also true -> flush wins, stall=0; second br_taken during FLUSH -> count restarts, 2 more flush_id cycles.
- Long op with rd=0, and a read of x0 -> pending stays 0, no stall.
- Assert reset during FLUSH with pending=32'h0000_0120 -> pending=0, busy=0, flush_id=0 immediately; with PIPE_SCHED_PERF_EN, both counters read 0; after 3 stall cycles perf_stall_cnt=3.
